// File: rtl/card_geom_pkg.sv
// Card-grid geometry shared by the card renderer and the click picker, plus
// the picker FSM state type. Both sides import this so they cannot disagree.
package card_geom_pkg;

  localparam int GRID_X0     = 32;
  localparam int GRID_X1     = 607;
  localparam int CARD_W_LOG2 = 5;
  localparam int COLS        = 18;
  localparam int ROWS        = 8;
  localparam int TOP_Y0      = 19;
  localparam int TOP_H       = 55;
  localparam int TOP_ROWS    = 6;
  localparam int BOT_Y0      = 360;
  localparam int BOT_H       = 50;
  localparam int BOT_END     = 459;

  localparam int BOT_ROWS = ROWS - TOP_ROWS;
  localparam int TOP_END  = TOP_Y0 + TOP_ROWS * TOP_H - 1;
  localparam int SLOTS    = ROWS * COLS;
  localparam int CODE_W   = 6;
  localparam int MAP_W    = SLOTS * CODE_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_LOOKUP,
    ST_UPDATE
  } pick_state_t;

  // row*18 + col without a multiplier: row*16 + row*2 + col.
  function automatic logic [7:0] slot_idx(input logic [3:0] row, input logic [4:0] col);
    return {row, 4'b0000} + {3'b000, row, 1'b0} + {3'b000, col};
  endfunction

endpackage

// File: rtl/card_picker_if.sv
// Mouse/game-control side of the card picker: click inputs, card map and the
// selection results handed back to game control and the display top.
interface card_picker_if;
  import card_geom_pkg::*;

  logic               interboard_rst;
  logic               en_pick;
  logic               clear_sel;
  logic [9:0]         mouse_x;
  logic [9:0]         mouse_y;
  logic               l_click;
  logic [MAP_W-1:0]   map;
  logic [SLOTS-1:0]   sel_card;
  logic [7:0]         sel_cnt;
  logic               pick_valid;
  logic               pick_reject;
  logic               pick_miss;
  logic [7:0]         pick_idx;
  logic [CODE_W-1:0]  pick_code;
  logic               busy;

  modport master (
    output interboard_rst, en_pick, clear_sel, mouse_x, mouse_y, l_click, map,
    input  sel_card, sel_cnt, pick_valid, pick_reject, pick_miss, pick_idx, pick_code, busy
  );

  modport slave (
    input  interboard_rst, en_pick, clear_sel, mouse_x, mouse_y, l_click, map,
    output sel_card, sel_cnt, pick_valid, pick_reject, pick_miss, pick_idx, pick_code, busy
  );

endinterface

// File: rtl/pick_row_div.sv
// Iterative divide-by-constant: repeatedly subtracts step from dy, at most once
// per cycle, for a fixed 8-cycle run after start.
module pick_row_div
  import card_geom_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] dy,
  input  logic [5:0] step,
  input  logic [3:0] max_q,
  output logic [3:0] quotient,
  output logic       in_range
);

  logic [9:0] rem;
  logic [5:0] step_q;
  logic [3:0] max_q_q;
  logic [2:0] cnt;
  logic       run;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem      <= '0;
      step_q   <= '0;
      max_q_q  <= '0;
      quotient <= '0;
      cnt      <= '0;
      run      <= 1'b0;
    end else if (start) begin
      rem      <= dy;
      step_q   <= step;
      max_q_q  <= max_q;
      quotient <= '0;
      cnt      <= '0;
      run      <= 1'b1;
    end else if (run) begin
      if (rem >= {4'b0000, step_q}) begin
        rem      <= rem - {4'b0000, step_q};
        quotient <= quotient + 4'd1;
      end
      cnt <= cnt + 3'd1;
      if (cnt == 3'd7) run <= 1'b0;
    end
  end

  // A leftover >= step means the run ended before the division finished.
  assign in_range = (quotient < max_q_q) && (rem < {4'b0000, step_q});

endmodule

// File: rtl/card_picker.sv
// Maps a left-click pixel position to a card slot, looks up its code and
// toggles that slot in the selection bitmap, bounded by MAX_SEL selections.
module card_picker
  import card_geom_pkg::*;
#(
  parameter int          MAX_SEL    = 8,
  parameter logic [5:0]  EMPTY_CODE = 6'd63
) (
  input  logic         clk,
  input  logic         rst,
  card_picker_if.slave bus
);

  pick_state_t       state;
  logic              l_click_q;
  logic [2:0]        dec_cnt;
  logic [9:0]        x_lat;
  logic [9:0]        y_lat;
  logic              hit;

  logic              sync_clr;
  logic              take;
  logic              bottom_in;
  logic [9:0]        dy_in;
  logic [5:0]        step_in;
  logic [3:0]        max_q_in;
  logic [3:0]        quotient;
  logic              div_in_range;
  logic              x_ok;
  logic              y_ok;
  logic [3:0]        row;
  logic [4:0]        col;
  logic [7:0]        idx;
  logic [9:0]        map_off;
  logic [CODE_W-1:0] lookup_code;

  assign sync_clr = bus.clear_sel | bus.interboard_rst;
  assign take     = (state == ST_IDLE) && bus.en_pick && bus.l_click && !l_click_q && !sync_clr;

  // Divider operands come from the live mouse position on the click cycle.
  assign bottom_in = bus.mouse_y >= 10'(BOT_Y0);
  assign dy_in     = bottom_in ? bus.mouse_y - 10'(BOT_Y0) : bus.mouse_y - 10'(TOP_Y0);
  assign step_in   = bottom_in ? 6'(BOT_H) : 6'(TOP_H);
  assign max_q_in  = bottom_in ? 4'(BOT_ROWS) : 4'(TOP_ROWS);

  pick_row_div u_row_div (
    .clk      (clk),
    .rst      (rst),
    .start    (take),
    .dy       (dy_in),
    .step     (step_in),
    .max_q    (max_q_in),
    .quotient (quotient),
    .in_range (div_in_range)
  );

  assign x_ok = (x_lat >= 10'(GRID_X0)) && (x_lat <= 10'(GRID_X1));
  assign y_ok = ((y_lat >= 10'(TOP_Y0)) && (y_lat <= 10'(TOP_END))) ||
                ((y_lat >= 10'(BOT_Y0)) && (y_lat <= 10'(BOT_END)));
  assign col  = 5'((x_lat - 10'(GRID_X0)) >> CARD_W_LOG2);
  assign row  = (y_lat >= 10'(BOT_Y0)) ? quotient + 4'(TOP_ROWS) : quotient;
  assign idx  = slot_idx(row, col);
  assign map_off = {2'b00, idx} * 10'(CODE_W);

  // NOTE: default first so no path through always_comb leaves lookup_code
  // unassigned, which would infer a latch.
  always_comb begin
    lookup_code = EMPTY_CODE;
    if (idx < 8'(SLOTS)) lookup_code = bus.map[map_off +: CODE_W];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= ST_IDLE;
      l_click_q       <= 1'b0;
      dec_cnt         <= '0;
      x_lat           <= '0;
      y_lat           <= '0;
      hit             <= 1'b0;
      bus.sel_card    <= '0;
      bus.sel_cnt     <= '0;
      bus.pick_valid  <= 1'b0;
      bus.pick_reject <= 1'b0;
      bus.pick_miss   <= 1'b0;
      bus.pick_idx    <= '0;
      bus.pick_code   <= '0;
      bus.busy        <= 1'b0;
    end else begin
      l_click_q       <= bus.l_click;
      bus.pick_valid  <= 1'b0;
      bus.pick_reject <= 1'b0;
      bus.pick_miss   <= 1'b0;
      if (sync_clr) begin
        bus.sel_card <= '0;
        bus.sel_cnt  <= '0;
        bus.busy     <= 1'b0;
        state        <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: if (take) begin
            x_lat    <= bus.mouse_x;
            y_lat    <= bus.mouse_y;
            dec_cnt  <= '0;
            bus.busy <= 1'b1;
            state    <= ST_DECODE;
          end
          ST_DECODE: begin
            dec_cnt <= dec_cnt + 3'd1;
            if (dec_cnt == 3'd7) state <= ST_LOOKUP;
          end
          ST_LOOKUP: begin
            bus.pick_idx  <= idx;
            bus.pick_code <= lookup_code;
            hit           <= x_ok && y_ok && div_in_range;
            state         <= ST_UPDATE;
          end
          ST_UPDATE: begin
            if (!hit || bus.pick_code == EMPTY_CODE) begin
              bus.pick_miss <= 1'b1;
            end else if (bus.sel_card[bus.pick_idx]) begin
              bus.sel_card[bus.pick_idx] <= 1'b0;
              bus.sel_cnt                <= bus.sel_cnt - 8'd1;
              bus.pick_valid             <= 1'b1;
            end else if (bus.sel_cnt < 8'(MAX_SEL)) begin
              bus.sel_card[bus.pick_idx] <= 1'b1;
              bus.sel_cnt                <= bus.sel_cnt + 8'd1;
              bus.pick_valid             <= 1'b1;
            end else begin
              bus.pick_valid  <= 1'b1;
              bus.pick_reject <= 1'b1;
            end
            bus.busy <= 1'b0;
            state    <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_card_picker.sv
// Directed bench for card_picker (MAX_SEL=4): hits, misses, selection limit,
// clears, ignored clicks and asynchronous reset during a decode.
module tb_card_picker;
  import card_geom_pkg::*;

  typedef struct {
    int x;
    int y;
    int idx;
    int code;
  } hit_t;

  logic clk = 1'b0;
  logic rst;
  card_picker_if bus ();

  card_picker #(.MAX_SEL(4), .EMPTY_CODE(6'd63)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [143:0] exp_sel;
  int          exp_cnt;

  int          lat;
  logic        r_valid, r_miss, r_reject;
  logic [7:0]  r_idx;
  logic [5:0]  r_code;

  // Click at (x,y) and wait up to 20 cycles for the result pulse.
  task automatic do_click(input int x, input int y);
    @(negedge clk);
    bus.mouse_x = 10'(x);
    bus.mouse_y = 10'(y);
    bus.l_click = 1'b1;
    @(posedge clk);
    #1 bus.l_click = 1'b0;
    lat = -1; r_valid = 0; r_miss = 0; r_reject = 0; r_idx = '0; r_code = '0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.pick_valid || bus.pick_miss) begin
        lat = k; r_valid = bus.pick_valid; r_miss = bus.pick_miss;
        r_reject = bus.pick_reject; r_idx = bus.pick_idx; r_code = bus.pick_code;
        break;
      end
    end
  endtask

  task automatic test_reset();
    n_cmp++; if (bus.sel_card !== '0) begin n_bad++; $display("FAIL reset_sel_card got %h want 0", bus.sel_card); end
    n_cmp++; if (bus.sel_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_sel_cnt got %0d want 0", bus.sel_cnt); end
    n_cmp++; if ({bus.pick_idx, bus.pick_code} !== 14'd0) begin n_bad++; $display("FAIL reset_pick got idx %0d code %0d want 0 0", bus.pick_idx, bus.pick_code); end
    n_cmp++; if ({bus.pick_valid, bus.pick_reject, bus.pick_miss, bus.busy} !== 4'b0) begin n_bad++;
      $display("FAIL reset_pulses got %b want 0000", {bus.pick_valid, bus.pick_reject, bus.pick_miss, bus.busy}); end
  endtask

  // Accepted clicks: a toggle model of the bitmap predicts select/deselect/reject.
  task automatic run_hits(input hit_t h [], input string tag);
    logic exp_rej;
    foreach (h[i]) begin
      do_click(h[i].x, h[i].y);
      exp_rej = 1'b0;
      if (exp_sel[h[i].idx]) begin exp_sel[h[i].idx] = 1'b0; exp_cnt--; end
      else if (exp_cnt < 4) begin exp_sel[h[i].idx] = 1'b1; exp_cnt++; end
      else exp_rej = 1'b1;
      n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL %s[%0d]_latency got %0d want 10", tag, i, lat); end
      n_cmp++; if ({r_valid, r_miss, r_reject} !== {2'b10, exp_rej}) begin n_bad++;
        $display("FAIL %s[%0d]_flags valid/miss/reject got %b want %b", tag, i, {r_valid, r_miss, r_reject}, {2'b10, exp_rej}); end
      n_cmp++; if (r_idx !== 8'(h[i].idx) || r_code !== 6'(h[i].code)) begin n_bad++;
        $display("FAIL %s[%0d]_slot got idx %0d code %0d want idx %0d code %0d", tag, i, r_idx, r_code, h[i].idx, h[i].code); end
      n_cmp++; if (bus.sel_card !== exp_sel || bus.sel_cnt !== 8'(exp_cnt)) begin n_bad++;
        $display("FAIL %s[%0d]_sel got %h cnt %0d want %h cnt %0d", tag, i, bus.sel_card, bus.sel_cnt, exp_sel, exp_cnt); end
    end
  endtask

  task automatic test_hits();
    hit_t h [];
    // slot 0, last slot twice (select then deselect), then grid boundary corners
    h = '{'{40, 20, 0, 12}, '{600, 458, 143, 5}, '{600, 458, 143, 5},
          '{607, 348, 107, 47}, '{32, 360, 108, 48}};
    run_hits(h, "hit");
  endtask

  task automatic test_misses();
    int pts [6][2];
    pts = '{'{100, 350}, '{20, 100}, '{40, 460}, '{32, 359}, '{608, 20}, '{32, 18}};
    foreach (pts[i]) begin
      do_click(pts[i][0], pts[i][1]);
      n_cmp++; if (lat !== 10 || r_miss !== 1'b1 || r_valid !== 1'b0) begin n_bad++;
        $display("FAIL miss[%0d] got lat %0d miss %b valid %b want 10 1 0", i, lat, r_miss, r_valid); end
      n_cmp++; if (bus.sel_card !== exp_sel || bus.sel_cnt !== 8'(exp_cnt)) begin n_bad++;
        $display("FAIL miss[%0d]_sel got %h cnt %0d want %h cnt %0d", i, bus.sel_card, bus.sel_cnt, exp_sel, exp_cnt); end
    end
    do_click(70, 80);
    n_cmp++; if (lat !== 10 || r_miss !== 1'b1 || r_valid !== 1'b0) begin n_bad++;
      $display("FAIL empty_slot got lat %0d miss %b valid %b want 10 1 0", lat, r_miss, r_valid); end
    n_cmp++; if (r_idx !== 8'd19 || r_code !== 6'd63) begin n_bad++;
      $display("FAIL empty_slot_idx got idx %0d code %0d want 19 63", r_idx, r_code); end
    n_cmp++; if (bus.sel_card !== exp_sel) begin n_bad++; $display("FAIL empty_slot_sel got %h want %h", bus.sel_card, exp_sel); end
  endtask

  task automatic test_max_sel();
    hit_t h [];
    // fill to 4, refuse a 5th, deselect one, then the 5th is accepted
    h = '{'{104, 20, 2, 2}, '{136, 80, 21, 21}, '{104, 20, 2, 2}, '{136, 80, 21, 21}};
    run_hits(h, "max");
  endtask

  task automatic test_clear_on_update();
    @(negedge clk);
    bus.mouse_x = 10'd40; bus.mouse_y = 10'd20; bus.l_click = 1'b1;
    @(posedge clk);
    #1 bus.l_click = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL clear_busy_before got %b want 1", bus.busy); end
    bus.clear_sel = 1'b1;
    @(posedge clk);
    #1 bus.clear_sel = 1'b0;
    exp_sel = '0; exp_cnt = 0;
    n_cmp++; if ({bus.pick_valid, bus.pick_miss, bus.pick_reject, bus.busy} !== 4'b0) begin n_bad++;
      $display("FAIL clear_no_pulse got %b want 0000", {bus.pick_valid, bus.pick_miss, bus.pick_reject, bus.busy}); end
    n_cmp++; if (bus.sel_card !== '0 || bus.sel_cnt !== 8'd0) begin n_bad++;
      $display("FAIL clear_sel got %h cnt %0d want 0 0", bus.sel_card, bus.sel_cnt); end
  endtask

  task automatic test_interboard();
    do_click(40, 20);
    n_cmp++; if (bus.sel_cnt !== 8'd1 || r_valid !== 1'b1) begin n_bad++;
      $display("FAIL ib_pre got cnt %0d valid %b want 1 1", bus.sel_cnt, r_valid); end
    @(negedge clk) bus.interboard_rst = 1'b1;
    @(negedge clk) bus.interboard_rst = 1'b0;
    n_cmp++; if (bus.sel_card !== '0 || bus.sel_cnt !== 8'd0) begin n_bad++;
      $display("FAIL ib_clear got %h cnt %0d want 0 0", bus.sel_card, bus.sel_cnt); end
  endtask

  task automatic test_en_pick_low();
    int seen;
    bus.en_pick = 1'b0;
    do_click(40, 20);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (bus.pick_valid || bus.pick_miss || bus.busy) seen++;
    end
    n_cmp++; if (lat !== -1 || seen !== 0) begin n_bad++;
      $display("FAIL en_pick_low got lat %0d activity %0d want -1 0", lat, seen); end
    bus.en_pick = 1'b1;
  endtask

  task automatic test_reset_mid();
    int seen;
    do_click(72, 20);
    n_cmp++; if (bus.sel_cnt !== 8'd1 || bus.pick_idx !== 8'd1) begin n_bad++;
      $display("FAIL rstmid_pre got cnt %0d idx %0d want 1 1", bus.sel_cnt, bus.pick_idx); end
    @(negedge clk);
    bus.mouse_x = 10'd104; bus.mouse_y = 10'd20; bus.l_click = 1'b1;
    @(posedge clk);
    #1 bus.l_click = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_cmp++; if (bus.sel_card !== '0 || bus.sel_cnt !== 8'd0 || bus.pick_idx !== 8'd0 || bus.busy !== 1'b0) begin n_bad++;
      $display("FAIL rstmid_values got sel %h cnt %0d idx %0d busy %b want 0 0 0 0", bus.sel_card, bus.sel_cnt, bus.pick_idx, bus.busy); end
    @(negedge clk) rst = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (bus.pick_valid || bus.pick_miss) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rstmid_no_pulse got %0d pulses want 0", seen); end
    exp_sel = '0; exp_cnt = 0;
  endtask

  task automatic test_back_to_back();
    int seen;
    @(negedge clk);
    bus.mouse_x = 10'd40; bus.mouse_y = 10'd20; bus.l_click = 1'b1;
    @(negedge clk) bus.l_click = 1'b0;
    repeat (3) @(negedge clk);
    bus.mouse_x = 10'd72; bus.l_click = 1'b1;
    @(negedge clk) bus.l_click = 1'b0;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (bus.pick_valid || bus.pick_miss) seen++;
    end
    exp_sel = '0; exp_sel[0] = 1'b1; exp_cnt = 1;
    n_cmp++; if (seen !== 1) begin n_bad++; $display("FAIL b2b_pulses got %0d want 1", seen); end
    n_cmp++; if (bus.sel_card !== exp_sel || bus.sel_cnt !== 8'd1) begin n_bad++;
      $display("FAIL b2b_sel got %h cnt %0d want %h 1", bus.sel_card, bus.sel_cnt, exp_sel); end
  endtask

  initial begin
    rst = 1'b0;
    bus.interboard_rst = 1'b0;
    bus.en_pick = 1'b1;
    bus.clear_sel = 1'b0;
    bus.mouse_x = '0;
    bus.mouse_y = '0;
    bus.l_click = 1'b0;
    for (int i = 0; i < 144; i++) bus.map[i*6 +: 6] = 6'(i % 60);
    bus.map[0*6 +: 6]   = 6'd12;
    bus.map[143*6 +: 6] = 6'd5;
    bus.map[19*6 +: 6]  = 6'd63;
    exp_sel = '0;
    exp_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);

    test_hits();
    test_misses();
    test_max_sel();
    test_clear_on_update();
    test_interboard();
    test_en_pick_low();
    test_reset_mid();
    test_back_to_back();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/card_picker.md
Name: card_picker

Overview:
- Inverse of the card renderer: converts a mouse click's pixel coordinates back into a card-grid index (8 rows x 18 columns).
- Looks up the card code at that index and toggles the index's bit in the sel_card vector consumed by the display top.
- Sits between the mouse module and game control. Runs multi-cycle: an iterative row decode, then a map lookup, then an update.

Parameters:
MAX_SEL, 8, maximum number of simultaneously selected cards.
EMPTY_CODE, 63, 6-bit map code meaning "no card in slot".

Ports:
clk  input  1  system clock (100 MHz)
rst  input  1  asynchronous, active-low reset
interboard_rst  input  1  synchronous clear request from the peer board, active-high
en_pick  input  1  picking allowed (our turn); when low, clicks are ignored
clear_sel  input  1  synchronous clear of all selections, active-high
mouse_x  input  10  mouse pixel column
mouse_y  input  10  mouse pixel row
l_click  input  1  left button level
map  input  8*18*6  card codes; slot idx occupies map[idx*6 +: 6]
sel_card  output  144  selection bitmap; bit idx = slot idx
sel_cnt  output  8  number of set bits in sel_card
pick_valid  output  1  one-cycle pulse: a card slot was hit and processed
pick_reject  output  1  qualifies pick_valid: select refused (MAX_SEL reached)
pick_miss  output  1  one-cycle pulse: click hit a gap, outside the grid, or an EMPTY_CODE slot
pick_idx  output  8  last processed slot index (row*18+col)
pick_code  output  6  map code of that slot
busy  output  1  high from DECODE through UPDATE

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE.
  - sel_card=0, sel_cnt=0, pick_idx=0, pick_code=0.
  - All pulse outputs and busy are 0.
- Geometry (decided; shared with the renderer):
  - Columns: col=(x-32)>>5, valid for 32<=x<=607.
  - Top rows 0..5: 55 px tall, starting at y=19, valid for 19<=y<=348.
  - Bottom rows 6..7: 50 px tall, starting at y=360, valid for 360<=y<=459.
  - Every other coordinate is a miss.
- Click detect: l_click is registered, and a rising edge is sampled in IDLE only.
  - The edge is taken when en_pick=1. mouse_x and mouse_y are latched on the same cycle.
  - Edges while busy or while en_pick=0 are dropped; no queueing.
- FSM: IDLE -> DECODE -> LOOKUP -> UPDATE -> IDLE.
  - DECODE lasts exactly 8 cycles (internal counter).
    - Computes dy = y - base.
    - Subtracts the row step (55 or 50) while the remainder >= step, at most once per cycle.
    - Also computes col and the range checks.
  - LOOKUP (1 cycle):
    - idx = row*18+col, formed by shift-add (row*16 + row*2 + col), 8-bit.
    - Registers code = map[idx*6 +: 6] into pick_code.
  - UPDATE (1 cycle). The result is chosen by the first matching rule:
    - Out of range, or code==EMPTY_CODE: pick_miss=1; pick_idx and pick_code still updated.
    - sel_card[idx]=1: clear the bit, sel_cnt-1, pick_valid=1.
    - sel_card[idx]=0 and sel_cnt<MAX_SEL: set the bit, sel_cnt+1, pick_valid=1.
    - sel_card[idx]=0 and sel_cnt==MAX_SEL: no change, pick_valid=1, pick_reject=1.
- Fixed latency: a click edge registered at cycle N gives its pulse at cycle N+10.
- Deselect is always allowed, even when sel_cnt==MAX_SEL.
- clear_sel or interboard_rst:
  - Effect: sel_card=0 and sel_cnt=0 on the next edge, and the FSM returns to IDLE with no pulse.
  - Priority: wins over a simultaneous UPDATE.
- sel_cnt never exceeds MAX_SEL and never underflows.
- rst asserted mid-operation: immediate reset values; the latched click is discarded.

Decomposition:
- Package card_geom_pkg:
  - Geometry constants: GRID_X0=32, CARD_W_LOG2=5, COLS=18, ROWS=8, TOP_Y0=19, TOP_H=55, TOP_ROWS=6, BOT_Y0=360, BOT_H=50, BOT_END=459, GRID_X1=607.
  - FSM state typedef.
  - Shared with the draw-card logic so that renderer and picker geometry cannot diverge.
- Sub-module pick_row_div: iterative subtract-by-constant divider.
  - Inputs: start, dy, step, max_q.
  - Outputs: quotient, in_range.
  - Fixed 8-cycle run.

Test Plan:
- Slot 0:
  - Setup: map slot 0 = 12; click at (40,20).
  - Required: pick_valid at N+10, pick_idx=0, pick_code=12, sel_card[0]=1, sel_cnt=1.
- Last slot:
  - Setup: map slot 143 = 5; click at (600,458).
  - Required: col=17, row=7, pick_idx=143, sel_card[143]=1.
  - Click the same point again: sel_card[143]=0, sel_cnt decrements.
- Misses: clicks at (100,350) (gap), (20,100) (x<32) and (40,460) (y past bottom row).
  - Required: pick_miss pulse each time; sel_card unchanged.
  - Setup: slot 19 = EMPTY_CODE. Click at (70,80): pick_miss, pick_idx=19.
- MAX_SEL overrun: with MAX_SEL=4, select 4 distinct cards, then click a 5th.
  - Required: pick_valid=1, pick_reject=1, sel_cnt stays 4.
  - Then deselect one card: accepted, sel_cnt=3.
- Clear and ignored clicks: assert clear_sel on the same cycle as an UPDATE.
  - Required: sel_card=0, sel_cnt=0, no pulse.
  - Then with en_pick=0, a click: no pulse within 20 cycles.
- Reset mid-op: assert rst during DECODE cycle 3.
  - Required: outputs at reset values immediately; no pulse after release.
  - Then a second click during busy: dropped, only one pulse seen.
